// File: rtl/saturating_accumulator.sv
// Windowed saturating reducer: sums len samples with a clamp at max, presents one result per window.
// Optional sticky clamp flag is built when SATURATING_ACCUMULATOR_SAT_FLAG_EN is defined.
module saturating_accumulator #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 4
) (
  input  logic               _i_clk,
  input  logic               _i_rst_n,
  input  logic               _i_in_valid,
  input  logic [WIDTH-1:0]   _i_in_data,
  input  logic [COUNT_W-1:0] _i_len,
  input  logic [WIDTH-1:0]   _i_max,
  input  logic               _i_out_ready,
  output logic [WIDTH+2:0]   __output
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   max_q, max_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] len_q, len_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready;
  logic               saturated_bit;

  // In IDLE the window is about to open, so operands come from the live inputs and a zeroed accumulator.
  logic               first;
  logic [WIDTH-1:0]   base_acc;
  logic [COUNT_W-1:0] base_cnt;
  logic [WIDTH-1:0]   eff_max;
  logic [COUNT_W-1:0] eff_len;
  logic [WIDTH:0]     sum_ext;
  logic               clamp;
  logic [WIDTH-1:0]   new_acc;
  logic [COUNT_W-1:0] new_cnt;

  assign in_ready = (state_q != HOLD);
  assign first    = (state_q == IDLE);
  assign base_acc = first ? '0 : acc_q;
  assign base_cnt = first ? '0 : count_q;
  assign eff_max  = first ? _i_max : max_q;
  assign eff_len  = first ? ((_i_len == '0) ? COUNT_W'(1) : _i_len) : len_q;
  assign sum_ext  = {1'b0, base_acc} + {1'b0, _i_in_data};
  assign clamp    = (sum_ext > {1'b0, eff_max});
  assign new_acc  = clamp ? eff_max : sum_ext[WIDTH-1:0];
  assign new_cnt  = base_cnt + COUNT_W'(1);

`ifdef SATURATING_ACCUMULATOR_SAT_FLAG_EN
  logic sat_q, sat_d;
  logic saturated_q, saturated_d;
  logic base_sat;
  assign base_sat      = first ? 1'b0 : sat_q;
  assign saturated_bit = saturated_q;
`else
  assign saturated_bit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    len_d       = len_q;
    max_d       = max_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
`ifdef SATURATING_ACCUMULATOR_SAT_FLAG_EN
    sat_d       = sat_q;
    saturated_d = saturated_q;
`endif
    case (state_q)
      HOLD: begin
        if (_i_out_ready) begin
          state_d     = IDLE;
          acc_d       = '0;
          count_d     = '0;
          out_valid_d = 1'b0;
`ifdef SATURATING_ACCUMULATOR_SAT_FLAG_EN
          sat_d       = 1'b0;
`endif
        end
      end
      default: begin
        if (_i_in_valid) begin
          len_d   = eff_len;
          max_d   = eff_max;
          acc_d   = new_acc;
          count_d = new_cnt;
`ifdef SATURATING_ACCUMULATOR_SAT_FLAG_EN
          sat_d   = base_sat | clamp;
`endif
          if (new_cnt == eff_len) begin
            state_d     = HOLD;
            sum_d       = new_acc;
            out_valid_d = 1'b1;
`ifdef SATURATING_ACCUMULATOR_SAT_FLAG_EN
            saturated_d = base_sat | clamp;
`endif
          end else begin
            state_d = ACCUM;
          end
        end
      end
    endcase
  end

  always_ff @(posedge _i_clk or negedge _i_rst_n) begin
    if (!_i_rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      len_q       <= '0;
      max_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      len_q       <= len_d;
      max_q       <= max_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef SATURATING_ACCUMULATOR_SAT_FLAG_EN
  always_ff @(posedge _i_clk or negedge _i_rst_n) begin
    if (!_i_rst_n) begin
      sat_q       <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      sat_q       <= sat_d;
      saturated_q <= saturated_d;
    end
  end
`endif

  assign __output = {in_ready, out_valid_q, saturated_bit, sum_q};

endmodule

// File: tb/tb_saturating_accumulator.sv
// Self-checking bench for saturating_accumulator: directed test-plan windows, then random traffic vs a window model.
module tb_saturating_accumulator;

  localparam int WIDTH   = 8;
  localparam int COUNT_W = 4;
`ifdef SATURATING_ACCUMULATOR_SAT_FLAG_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic [WIDTH-1:0]   in_data = '0;
  logic [COUNT_W-1:0] len = '0;
  logic [WIDTH-1:0]   max_v = '0;
  logic               out_ready = 1'b0;
  logic [WIDTH+2:0]   dout;

  int n_cmp = 0;
  int n_bad = 0;

  // Window-level reference: a result is either pending or not, and an open window has a running total.
  bit m_pending, m_open, m_sat, m_satres;
  int m_acc, m_n, m_len, m_max, m_sum;

  saturating_accumulator #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    ._i_clk       (clk),
    ._i_rst_n     (rst_n),
    ._i_in_valid  (in_valid),
    ._i_in_data   (in_data),
    ._i_len       (len),
    ._i_max       (max_v),
    ._i_out_ready (out_ready),
    .__output     (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = 0; m_open = 0; m_sat = 0; m_satres = 0;
    m_acc = 0; m_n = 0; m_len = 0; m_max = 0; m_sum = 0;
  endtask

  task automatic model_edge(input bit v, input int d, input int l, input int mx, input bit r);
    if (m_pending) begin
      if (r) begin
        m_pending = 0; m_open = 0; m_acc = 0; m_n = 0; m_sat = 0;
      end
    end else if (v) begin
      if (!m_open) begin
        m_len = (l == 0) ? 1 : l;
        m_max = mx; m_acc = 0; m_n = 0; m_sat = 0; m_open = 1;
      end
      if (m_acc + d > m_max) begin
        m_acc = m_max; m_sat = 1;
      end else begin
        m_acc = m_acc + d;
      end
      m_n++;
      if (m_n == m_len) begin
        m_pending = 1; m_open = 0; m_sum = m_acc; m_satres = m_sat;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".in_ready"},  dout[WIDTH+2], !m_pending);
    chk({tag, ".out_valid"}, dout[WIDTH+1], m_pending);
    chk({tag, ".saturated"}, dout[WIDTH],   SAT_EN ? m_satres : 1'b0);
    chk({tag, ".sum"},       dout[WIDTH-1:0], m_sum);
  endtask

  // One clock: drive inputs, take the edge in model and DUT, then compare 1 time unit later.
  task automatic cyc(input string tag, input bit v, input int d, input int l, input int mx, input bit r);
    in_valid = v; in_data = d[WIDTH-1:0]; len = l[COUNT_W-1:0]; max_v = mx[WIDTH-1:0]; out_ready = r;
    @(posedge clk);
    model_edge(v, d, l, mx, r);
    #1;
    check_model(tag);
    $display("cyc %-10s v=%0d d=%0d len=%0d max=%0d rdy=%0d -> out=%03h", tag, v, d, l, mx, r, dout);
  endtask

  initial begin
    model_reset();
    #1;
    chk("reset.in_ready",  dout[WIDTH+2], 1);
    chk("reset.out_valid", dout[WIDTH+1], 0);
    chk("reset.sum",       dout[WIDTH-1:0], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic window
    cyc("basic", 1, 1, 3, 200, 1);
    cyc("basic", 1, 2, 3, 200, 1);
    cyc("basic", 1, 3, 3, 200, 1);
    chk("basic.valid", dout[WIDTH+1], 1);
    chk("basic.sum",   dout[WIDTH-1:0], 6);
    chk("basic.sat",   dout[WIDTH], 0);
    cyc("basic", 0, 0, 3, 200, 1);
    chk("basic.valid_fall", dout[WIDTH+1], 0);
    chk("basic.ready_rise", dout[WIDTH+2], 1);

    // Clamp
    cyc("clamp", 1, 3, 2, 5, 1);
    cyc("clamp", 1, 4, 2, 5, 1);
    chk("clamp.sum", dout[WIDTH-1:0], 5);
    chk("clamp.sat", dout[WIDTH], SAT_EN);
    cyc("clamp", 0, 0, 2, 5, 1);
    cyc("clamp1", 1, 9, 1, 2, 1);
    chk("clamp1.sum", dout[WIDTH-1:0], 2);
    cyc("clamp1", 0, 0, 1, 2, 1);

    // Backpressure
    cyc("bp", 1, 1, 2, 10, 0);
    cyc("bp", 1, 1, 2, 10, 0);
    for (int i = 0; i < 5; i++) begin
      cyc("bp_hold", 1, 7, 2, 10, 0);
      chk("bp.sum",   dout[WIDTH-1:0], 2);
      chk("bp.valid", dout[WIDTH+1], 1);
      chk("bp.ready", dout[WIDTH+2], 0);
    end
    cyc("bp_rel", 1, 7, 2, 10, 1);
    chk("bp.valid_fall", dout[WIDTH+1], 0);
    chk("bp.ready_rise", dout[WIDTH+2], 1);
    cyc("bp_next", 1, 7, 1, 10, 1);
    chk("bp.next_sum", dout[WIDTH-1:0], 7);
    cyc("bp_next", 0, 0, 1, 10, 1);

    // Length 0 and gaps
    cyc("len0", 1, 7, 0, 200, 1);
    chk("len0.valid", dout[WIDTH+1], 1);
    chk("len0.sum",   dout[WIDTH-1:0], 7);
    cyc("len0", 0, 0, 0, 200, 1);
    cyc("gap", 1, 4, 2, 200, 1);
    for (int i = 0; i < 3; i++) cyc("gap_idle", 0, 99, 2, 200, 1);
    chk("gap.no_valid", dout[WIDTH+1], 0);
    cyc("gap", 1, 5, 2, 200, 1);
    chk("gap.sum", dout[WIDTH-1:0], 9);
    cyc("gap", 0, 0, 2, 200, 1);

    // Latched config
    cyc("latch", 1, 4, 2, 10, 1);
    cyc("latch", 1, 4, 5, 2, 1);
    chk("latch.valid", dout[WIDTH+1], 1);
    chk("latch.sum",   dout[WIDTH-1:0], 8);
    chk("latch.sat",   dout[WIDTH], 0);
    cyc("latch", 0, 0, 5, 2, 1);

    // Reset mid-window, asserted between edges
    cyc("rst", 1, 1, 3, 200, 1);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_model("rst_async");
    chk("rst.in_ready", dout[WIDTH+2], 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("post_rst", 1, 3, 1, 200, 1);
    chk("post_rst.sum", dout[WIDTH-1:0], 3);
    cyc("post_rst", 0, 0, 1, 200, 1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(9, 0) < 7), $urandom_range(255, 0), $urandom_range(4, 0),
          $urandom_range(255, 0), $urandom_range(1, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
